// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings, word width and sequencer state type
package alu_pkg;
  localparam logic [2:0] ARITH_ADD = 3'd0;
  localparam logic [2:0] ARITH_SUB = 3'd1;
  localparam logic [2:0] ARITH_INC = 3'd2;
  localparam logic [2:0] ARITH_DEC = 3'd3;
  localparam logic [2:0] ARITH_CMP = 3'd4;
  localparam int ARITH_WORD_W = 16;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_EXEC, SEQ_DONE} seq_state_t;
  function automatic logic arith_legal(input logic [2:0] c);
    return c <= ARITH_CMP;
  endfunction
endpackage

// File: rtl/alu_arithmetic_unit.sv
// alu_arithmetic_unit: combinational 16-bit add/sub/inc/dec, carry out is not-borrow for subtraction
module alu_arithmetic_unit
  import alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic [2:0]  ctrl,
  output logic [15:0] result,
  output logic        cout,
  output logic        overflow
);
  logic [15:0] bb;
  logic        c;
  logic [16:0] sum;
  logic        legal;
  always_comb begin
    bb = ctrl == ARITH_ADD ? b :
         (ctrl == ARITH_SUB || ctrl == ARITH_CMP) ? ~b :
         ctrl == ARITH_DEC ? 16'hFFFF : 16'h0000;
    c = ctrl == ARITH_INC ? 1'b1 : ctrl == ARITH_DEC ? 1'b0 : cin;
    sum = {1'b0, a} + {1'b0, bb} + {16'h0000, c};
    legal = arith_legal(ctrl);
    result = legal ? sum[15:0] : 16'h0000;
    cout = legal & sum[16];
    overflow = legal & (a[15] == bb[15]) & (sum[15] != a[15]);
  end
endmodule

// File: rtl/alu_seq_slice_ctrl.sv
// alu_seq_slice_ctrl: maps multiword op, first-slice flag and chained carry onto one arith-unit slice
module alu_seq_slice_ctrl
  import alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic        first,
  input  logic        carry,
  input  logic [15:0] b_in,
  output logic [2:0]  ctrl,
  output logic [15:0] b,
  output logic        cin
);
  logic sub, inc, dec;
  always_comb begin
    sub = op == ARITH_SUB || op == ARITH_CMP;
    inc = op == ARITH_INC;
    dec = op == ARITH_DEC;
    ctrl = sub ? ARITH_SUB : (first && inc) ? ARITH_INC : (first && dec) ? ARITH_DEC : ARITH_ADD;
    b = inc ? 16'h0000 : dec ? 16'hFFFF : b_in;
    cin = (first && (inc || dec)) ? 1'b0 : carry;
  end
endmodule

// File: rtl/alu_multiword_sequencer.sv
// alu_multiword_sequencer: NWORDS x 16-bit add/sub/cmp/inc/dec via the shared arith unit; ALU_SEQ_PERF_CNT_EN adds perf counters
module alu_multiword_sequencer
  import alu_pkg::*;
#(
  parameter int NWORDS = 4,
  localparam int W = ARITH_WORD_W * NWORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_ctrl,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic [15:0]  arith_a,
  output logic [15:0]  arith_b,
  output logic         arith_cin,
  output logic [2:0]   arith_ctrl,
  input  logic [15:0]  arith_result,
  input  logic         arith_cout,
  input  logic         arith_overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_cout,
  output logic         out_overflow,
  output logic         out_zero,
`ifdef ALU_SEQ_PERF_CNT_EN
  output logic         out_err,
  output logic [31:0]  perf_ops,
  output logic [31:0]  perf_busy
`else
  output logic         out_err
`endif
);
  localparam int IW = $clog2(NWORDS);
  seq_state_t state, state_n;
  logic [W-1:0] a_q, b_q;
  logic [2:0] op_q;
  logic carry_q, nz_q;
  logic [IW-1:0] idx_q;
  logic exec, last, accept;
  logic [2:0] sc_ctrl;
  logic [15:0] sc_b;
  logic sc_cin;
  assign exec = state == SEQ_EXEC;
  assign last = idx_q == IW'(NWORDS - 1);
  assign accept = state == SEQ_IDLE && in_valid;
  alu_seq_slice_ctrl u_slice_ctrl (
    .op    (op_q),
    .first (idx_q == '0),
    .carry (carry_q),
    .b_in  (b_q[idx_q*ARITH_WORD_W +: ARITH_WORD_W]),
    .ctrl  (sc_ctrl),
    .b     (sc_b),
    .cin   (sc_cin)
  );
  always_comb begin
    arith_a = exec ? a_q[idx_q*ARITH_WORD_W +: ARITH_WORD_W] : 16'h0000;
    arith_b = exec ? sc_b : 16'h0000;
    arith_cin = exec & sc_cin;
    arith_ctrl = exec ? sc_ctrl : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEQ_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    in_ready = state == SEQ_IDLE;
    out_valid = state == SEQ_DONE;
    if (accept) state_n = arith_legal(in_ctrl) ? SEQ_EXEC : SEQ_DONE;
    if (exec && last) state_n = SEQ_DONE;
    if (out_valid && out_ready) state_n = SEQ_IDLE;
  end
  // CMP runs as SUB but only its zero/carry flags are kept; the result stays cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= 3'd0;
      carry_q <= 1'b0;
      nz_q <= 1'b0;
      idx_q <= '0;
      out_result <= '0;
      out_cout <= 1'b0;
      out_overflow <= 1'b0;
      out_zero <= 1'b0;
      out_err <= 1'b0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
      op_q <= in_ctrl;
      carry_q <= in_cin;
      nz_q <= 1'b0;
      idx_q <= '0;
      out_result <= '0;
      out_cout <= 1'b0;
      out_overflow <= 1'b0;
      out_zero <= 1'b0;
      out_err <= !arith_legal(in_ctrl);
    end else if (exec) begin
      if (op_q != ARITH_CMP) out_result[idx_q*ARITH_WORD_W +: ARITH_WORD_W] <= arith_result;
      carry_q <= arith_cout;
      nz_q <= nz_q | (|arith_result);
      idx_q <= idx_q + 1'b1;
      if (last) begin
        out_cout <= arith_cout;
        out_overflow <= arith_overflow;
        out_zero <= !(nz_q | (|arith_result));
      end
    end
  end
`ifdef ALU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops <= 32'd0;
      perf_busy <= 32'd0;
    end else begin
      if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
      if (state != SEQ_IDLE) perf_busy <= perf_busy + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// tb_alu_multiword_sequencer: directed bench of the sequencer driving a real alu_arithmetic_unit
module tb_alu_multiword_sequencer;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] in_ctrl = 3'd0;
  logic [63:0] in_a = '0, in_b = '0;
  logic in_cin = 1'b0;
  logic [15:0] arith_a, arith_b, arith_result;
  logic arith_cin, arith_cout, arith_overflow;
  logic [2:0] arith_ctrl;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [63:0] out_result;
  logic out_cout, out_overflow, out_zero, out_err;
  int vectors = 0;
  int miscompares = 0;
  int lat;
  always #5 clk = ~clk;
  alu_multiword_sequencer #(.NWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .arith_a(arith_a), .arith_b(arith_b),
    .arith_cin(arith_cin), .arith_ctrl(arith_ctrl), .arith_result(arith_result),
    .arith_cout(arith_cout), .arith_overflow(arith_overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_cout(out_cout),
    .out_overflow(out_overflow), .out_zero(out_zero), .out_err(out_err)
  );
  alu_arithmetic_unit u_arith (
    .a(arith_a), .b(arith_b), .cin(arith_cin), .ctrl(arith_ctrl),
    .result(arith_result), .cout(arith_cout), .overflow(arith_overflow)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, output int l);
    in_ctrl = c;
    in_a = a;
    in_b = b;
    in_cin = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 64'hDEAD_BEEF_DEAD_BEEF;
    in_b = 64'h0F0F_F0F0_0F0F_F0F0;
    in_ctrl = ARITH_SUB;
    in_cin = ~ci;
    l = 1;
    while (!out_valid && l < 40) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_hs_valid"}, 64'(out_valid), 64'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_arith_a", 64'(arith_a), 64'd0);
    rst_n = 1'b1;
    issue(ARITH_ADD, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, lat);
    chk("add_latency", 64'(lat), 64'd5);
    chk("add_result", out_result, 64'h0000_0001_0000_0000);
    chk("add_cout", 64'(out_cout), 64'd0);
    chk("add_ovf", 64'(out_overflow), 64'd0);
    chk("add_zero", 64'(out_zero), 64'd0);
    chk("add_err", 64'(out_err), 64'd0);
    handshake("add");
    issue(ARITH_SUB, 64'h8000_0000_0000_0000, 64'h1, 1'b1, lat);
    chk("sub_latency", 64'(lat), 64'd5);
    chk("sub_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_cout", 64'(out_cout), 64'd1);
    chk("sub_ovf", 64'(out_overflow), 64'd1);
    chk("sub_zero", 64'(out_zero), 64'd0);
    handshake("sub");
    issue(ARITH_CMP, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, lat);
    chk("cmpeq_result", out_result, 64'd0);
    chk("cmpeq_zero", 64'(out_zero), 64'd1);
    chk("cmpeq_cout", 64'(out_cout), 64'd1);
    chk("cmpeq_ovf", 64'(out_overflow), 64'd0);
    handshake("cmpeq");
    issue(ARITH_CMP, 64'h1, 64'h2, 1'b1, lat);
    chk("cmplt_result", out_result, 64'd0);
    chk("cmplt_zero", 64'(out_zero), 64'd0);
    chk("cmplt_cout", 64'(out_cout), 64'd0);
    handshake("cmplt");
    issue(ARITH_INC, 64'h7FFF_FFFF_FFFF_FFFF, 64'h5555, 1'b1, lat);
    chk("inc_result", out_result, 64'h8000_0000_0000_0000);
    chk("inc_ovf", 64'(out_overflow), 64'd1);
    chk("inc_cout", 64'(out_cout), 64'd0);
    handshake("inc");
    issue(ARITH_DEC, 64'h0, 64'h1234, 1'b1, lat);
    chk("dec_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dec_cout", 64'(out_cout), 64'd0);
    chk("dec_ovf", 64'(out_overflow), 64'd0);
    chk("dec_zero", 64'(out_zero), 64'd0);
    handshake("dec");
    issue(ARITH_ADD, 64'h3, 64'h4, 1'b1, lat);
    chk("bp_result0", out_result, 64'h8);
    in_valid = 1'b1;
    in_ctrl = ARITH_SUB;
    in_a = 64'h9;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_result", out_result, 64'h8);
    end
    in_valid = 1'b0;
    handshake("bp");
    issue(3'b111, 64'h5, 64'h6, 1'b0, lat);
    chk("ill_latency", 64'(lat), 64'd1);
    chk("ill_err", 64'(out_err), 64'd1);
    chk("ill_result", out_result, 64'd0);
    chk("ill_cout", 64'(out_cout), 64'd0);
    chk("ill_zero", 64'(out_zero), 64'd0);
    handshake("ill");
    in_ctrl = ARITH_ADD;
    in_a = 64'h4444_3333_2222_1111;
    in_b = 64'h1;
    in_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_slice2_a", 64'(arith_a), 64'h3333);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", out_result, 64'd0);
    chk("mid_rst_cout", 64'(out_cout), 64'd0);
    chk("mid_rst_arith_a", 64'(arith_a), 64'd0);
    issue(ARITH_ADD, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, lat);
    chk("post_latency", 64'(lat), 64'd5);
    chk("post_result", out_result, 64'h0011_0022_0033_0045);
    chk("post_err", 64'(out_err), 64'd0);
    handshake("post");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_multiword_sequencer.md
Name: alu_multiword_sequencer

Overview:
Sequencer that runs multi-precision (NWORDS×16-bit) ADD/SUB/CMP/INC/DEC through the shared 16-bit arithmetic unit, one 16-bit slice per cycle, least-significant slice first. Carry is chained between slices. It owns the arith unit's input ports and registers each slice result. It sits between the ALU front-end (valid/ready) and the combinational arithmetic unit.

Parameters:
NWORDS, 4, number of 16-bit slices per operand (legal range 2..8); total operand width W = 16*NWORDS.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  sequencer can accept a request
in_ctrl  input  3  operation, alu_pkg ARITH_* encoding
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry-in for slice 0 (ADD/SUB/CMP only)
arith_a  output  16  slice of A driven to the arithmetic unit
arith_b  output  16  slice of B driven to the arithmetic unit
arith_cin  output  1  slice carry-in
arith_ctrl  output  3  slice operation
arith_result  input  16  unit result
arith_cout  input  1  unit carry-out
arith_overflow  input  1  unit overflow
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  W  result; all zero for CMP
out_cout  output  1  carry of the final slice
out_overflow  output  1  signed overflow of the final slice
out_zero  output  1  full-width difference or sum is zero
out_err  output  1  illegal in_ctrl

Behaviour:
- Interface: one clock, clk; synchronous active-low reset, rst_n. All state updates on the rising edge of clk.
- FSM states: IDLE, EXEC, DONE. Reset returns to IDLE from any state, including mid-EXEC. Reset values: out_* all 0, in_ready=1, slice index=0, arith_* outputs 0.
- IDLE: in_ready=1. When in_valid is high, the block latches a, b, ctrl, cin and the carry register (loaded with in_cin), clears the accumulated zero flag, sets the index to 0 and moves to EXEC. For an illegal ctrl it moves to DONE with out_err=1 and result and flags at 0.
- EXEC: in_ready=0. The block drives slice i combinationally from the registers. Each cycle it stores arith_result into result slice i, loads carry with arith_cout and ORs the slice into a nonzero accumulator. At i=NWORDS-1 it captures arith_cout and arith_overflow and moves to DONE.
- Slice control, slice 0: ADD uses ARITH_ADD with cin=latched cin. SUB and CMP use ARITH_SUB with cin=latched cin. INC uses ARITH_INC. DEC uses ARITH_DEC.
- Slice control, slices 1 and up: ADD uses ARITH_ADD with carry. SUB and CMP use ARITH_SUB with carry. INC uses ARITH_ADD with b=16'h0000 and carry. DEC uses ARITH_ADD with b=16'hFFFF and carry.
- CMP never issues ARITH_CMP to the unit. The slice result feeds only the zero flag, and out_result stays 0.
- Latency: out_valid rises exactly NWORDS+1 clocks after the accept edge. Illegal op: 1 clock.
- DONE: out_valid=1. Outputs hold stable while out_ready=0. On out_valid & out_ready the block clears out_valid and returns to IDLE; out_* data may hold stale values. A new request is accepted no earlier than the next cycle. Throughput is one op per NWORDS+2 cycles.
- Changes to in_a, in_b, in_ctrl during EXEC have no effect.

Optional Feature:
ALU_SEQ_PERF_CNT_EN.
- Defined: adds outputs perf_ops (32 bits) and perf_busy (32 bits). perf_ops increments on each out handshake. perf_busy increments on every cycle not in IDLE. Both wrap at 2^32 and are cleared by rst_n.
- Not defined: ports and counters are absent.

Decomposition:
- alu_pkg (existing) gains:
  - typedef enum logic [1:0] seq_state_t {SEQ_IDLE, SEQ_EXEC, SEQ_DONE};
  - localparam ARITH_WORD_W = 16.
  - Reuse the existing ARITH_* encodings.
- Sub-module: alu_seq_slice_ctrl. Combinational; maps (op, slice index==0, carry) to arith_ctrl, arith_b override and arith_cin. Everything else stays in the top level.

Test Plan (NWORDS=4, bench instantiates alu_arithmetic_unit behind the sequencer):
- ADD 0x0000_0000_FFFF_FFFF + 0x1, cin=0 -> result 0x0000_0001_0000_0000, cout 0, ovf 0, zero 0; out_valid exactly 5 clocks after accept.
- SUB 0x8000_0000_0000_0000 - 0x1, cin=1 -> 0x7FFF_FFFF_FFFF_FFFF, cout 1, ovf 1.
- CMP A=B=0x1234_5678_9ABC_DEF0, cin=1 -> result 0, zero 1, cout 1, ovf 0. CMP A=1, B=2 -> zero 0, cout 0.
- INC 0x7FFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000, ovf 1. DEC 0x0 -> 0xFFFF_FFFF_FFFF_FFFF, cout 0, ovf 0.
- Backpressure: hold out_ready=0 for 6 cycles -> outputs stable, in_ready 0, in_valid ignored. Illegal ctrl 3'b111 -> out_err 1 one clock after accept, result 0.
- rst_n low during EXEC slice 2 -> next cycle in IDLE, in_ready 1, out_valid 0, out_* 0. A following ADD completes correctly.
